// File: rtl/bigint_digit_serial_multiplier.sv
// Digit-serial unsigned multiplier: res = a*bi (2*WIDTH bits), one DIGIT-bit digit of bi per clock.
// Define MULT_ACC_EN to add the acc_in port and compute a*bi + acc_in modulo 2^(2*WIDTH).
module bigint_digit_serial_multiplier #(
  parameter int WIDTH = 80,
  parameter int DIGIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     bi,
`ifdef MULT_ACC_EN
  input  logic [2*WIDTH-1:0]   acc_in,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   res
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("bigint_digit_serial_multiplier: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   res_q;

  logic [WIDTH+DIGIT-1:0] pp_s;
  logic [2*WIDTH-1:0]     pp_ext_s;
  logic [2*WIDTH-1:0]     acc_d;
  logic [2*WIDTH-1:0]     acc_init_s;

  // Partial product of the current digit, aligned to its weight and added into the accumulator.
  always_comb begin
    pp_s     = {{DIGIT{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q[DIGIT-1:0]};
    pp_ext_s = '0;
    pp_ext_s[WIDTH+DIGIT-1:0] = pp_s;
    acc_d    = acc_q + (pp_ext_s << (cnt_q * DIGIT));
`ifdef MULT_ACC_EN
    acc_init_s = acc_in;
`else
    acc_init_s = '0;
`endif
  end

  // Control FSM and datapath registers; the final sum is written to res on the last RUN edge
  // so that res and done are both valid throughout the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (en) begin
            a_q     <= a;
            b_q     <= bi;
            acc_q   <= acc_init_s;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          b_q   <= b_q >> DIGIT;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            res_q   <= acc_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign res  = res_q;

endmodule

// File: tb/tb_bigint_digit_serial_multiplier.sv
// Directed bench for bigint_digit_serial_multiplier at WIDTH=80, DIGIT=16 (5 digits).
module tb_bigint_digit_serial_multiplier;

  localparam int W  = 80;
  localparam int D  = 16;
  localparam int ND = W / D;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [W-1:0]     a;
  logic [W-1:0]     bi;
`ifdef MULT_ACC_EN
  logic [2*W-1:0]   acc_in;
`endif
  logic             busy;
  logic             done;
  logic [2*W-1:0]   res;

  int n_checks;
  int n_fail;

  bigint_digit_serial_multiplier #(.WIDTH(W), .DIGIT(D)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .a      (a),
    .bi     (bi),
`ifdef MULT_ACC_EN
    .acc_in (acc_in),
`endif
    .busy   (busy),
    .done   (done),
    .res    (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Starts at a negedge in IDLE, returns at the negedge of the cycle after done.
  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2*W-1:0] accv, input logic [2*W-1:0] expv, input int rep_k);
    int pulses;
    logic [2*W-1:0] captured;
    pulses   = 0;
    captured = '0;
    a  = av;
    bi = bv;
`ifdef MULT_ACC_EN
    acc_in = accv;
`endif
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    a  = ~av;
    bi = ~bv;
`ifdef MULT_ACC_EN
    acc_in = ~accv;
`endif
    for (int k = 1; k <= ND + 1; k++) begin
      if (k == 1) check_eq({name, "_busy_c1"}, {159'd0, busy}, 160'd1);
      if (done) begin
        pulses++;
        captured = res;
      end
      if (k == ND + 1) check_eq({name, "_done_c6"}, {159'd0, done}, 160'd1);
      if (k == rep_k) begin
        en = 1'b1;
        a  = 80'h1234;
        bi = 80'h5678;
      end else begin
        en = 1'b0;
      end
      @(negedge clk);
    end
    en = 1'b0;
    check_eq({name, "_pulses"}, 160'(pulses), 160'd1);
    check_eq({name, "_res_at_done"}, captured, expv);
    check_eq({name, "_res_held"}, res, expv);
    check_eq({name, "_done_after"}, {159'd0, done}, 160'd0);
    check_eq({name, "_busy_after"}, {159'd0, busy}, 160'd0);
  endtask

  initial begin
    int rst_pulses;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    a     = '0;
    bi    = '0;
`ifdef MULT_ACC_EN
    acc_in = '0;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {159'd0, busy}, 160'd0);
    check_eq("rst_done", {159'd0, done}, 160'd0);
    check_eq("rst_res", res, 160'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("small", 80'd3, 80'd5, 160'd0, 160'd15, 0);
    run_op("max", {W{1'b1}}, {W{1'b1}}, 160'd0,
           160'hFFFF_FFFF_FFFF_FFFF_FFFE_0000_0000_0000_0000_0001, 0);
    run_op("zero_a", 80'd0, 80'h52f766_dbe90cfb52f766, 160'd0, 160'd0, 0);
    run_op("repulse_run", 80'd7, 80'd9, 160'd0, 160'd63, 2);
    run_op("repulse_done", 80'd11, 80'd13, 160'd0, 160'd143, ND + 1);
    run_op("hi_digit", 80'h8000_0000_0000_0000_0000, 80'd2, 160'd0,
           160'h1_0000_0000_0000_0000_0000, 0);

    // Abort an operation with reset during RUN cycle 3.
    a  = 80'hFFFF;
    bi = 80'hFFFF;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", {159'd0, busy}, 160'd0);
    check_eq("abort_res", res, 160'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rst_pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) rst_pulses++;
      @(negedge clk);
    end
    check_eq("abort_no_done", 160'(rst_pulses), 160'd0);
    check_eq("abort_res_idle", res, 160'd0);

    run_op("after_abort", 80'h1_0000_0000, 80'h3_0000_0000_0000, 160'd0,
           160'h3_0000_0000_0000_0000_0000, 0);
    run_op("back2back", 80'hFFFF, 80'h1_0000, 160'd0, 160'hFFFF_0000, 0);
`ifdef MULT_ACC_EN
    run_op("mac_wrap", 80'd2, 80'd3, {2*W{1'b1}}, 160'd5, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
